// File: rtl/systolic_output_collector_if.sv
// systolic_output_collector_if: handshake/data bundle between the systolic
// array bottom edge, the output collector and the downstream result writer.
// The master side drives the array lanes and the downstream ready; the slave
// side is the collector, which returns aligned words and status.
interface systolic_output_collector_if #(
    parameter int array_size = 9
);
    logic                      in_valid;
    logic [8*array_size-1:0]   macin;
    logic                      out_valid;
    logic                      out_ready;
    logic [8*array_size-1:0]   out_data;
    logic                      overflow;
    logic [15:0]               result_count;

    modport master (
        output in_valid,
        output macin,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  overflow,
        input  result_count
    );

    modport slave (
        input  in_valid,
        input  macin,
        input  out_ready,
        output out_valid,
        output out_data,
        output overflow,
        output result_count
    );
endinterface

// File: rtl/systolic_output_collector.sv
// systolic_output_collector: de-skews the column-staggered macout lanes of the
// systolic array into one aligned word per result vector, buffers the words in
// a small circular FIFO and hands them downstream over valid/ready.
// Optional feature: define SYSTOLIC_COLLECTOR_RELU_EN to clamp negative lanes
// (signed 8-bit) to zero at FIFO push time; undefined stores lanes unmodified.
module systolic_output_collector #(
    parameter int array_size = 9,
    parameter int fifo_depth = 4
) (
    input logic                          clk,
    input logic                          reset,
    systolic_output_collector_if.slave   bus
);
    localparam int W  = 8 * array_size;
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;

    logic [array_size-2:0] valid_sr_q;
    logic [W-1:0]          aligned;
    logic [W-1:0]          push_data;
    logic                  push;

    logic [W-1:0]          mem_q [fifo_depth];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           result_count_q, result_count_d;
    logic                  pop;
    logic                  full;
    logic                  write;

    // Valid marker travels alongside lane 0 so it emerges when the last lane arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr_q <= '0;
        end else begin
            for (int s = array_size - 2; s > 0; s--) begin
                valid_sr_q[s] <= valid_sr_q[s-1];
            end
            valid_sr_q[0] <= bus.in_valid;
        end
    end

    assign push = valid_sr_q[array_size-2];

    // Early lanes get longer delay lines so every lane of a vector lines up
    for (genvar j = 0; j < array_size - 1; j++) begin : g_lane
        localparam int D = array_size - 1 - j;
        logic [7:0] sr_q [D];

        // Per-lane delay line, cleared so in-flight lanes are discarded on reset
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < D; s++) begin
                    sr_q[s] <= '0;
                end
            end else begin
                sr_q[0] <= bus.macin[8*j +: 8];
                for (int s = 1; s < D; s++) begin
                    sr_q[s] <= sr_q[s-1];
                end
            end
        end

        assign aligned[8*j +: 8] = sr_q[D-1];
    end

    assign aligned[8*(array_size-1) +: 8] = bus.macin[8*(array_size-1) +: 8];

    // Optional clamp of negative lanes applied to the word entering the FIFO
    always_comb begin
        push_data = aligned;
`ifdef SYSTOLIC_COLLECTOR_RELU_EN
        for (int j = 0; j < array_size; j++) begin
            if (aligned[8*j+7]) begin
                push_data[8*j +: 8] = 8'h00;
            end
        end
`endif
    end

    // FIFO next state; a full FIFO still accepts a push when the head leaves this cycle
    always_comb begin
        pop            = out_valid_q & bus.out_ready;
        full           = (count_q == CW'(fifo_depth));
        write          = push & (~full | pop);
        wr_ptr_d       = write ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d       = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d        = count_q + CW'(write) - CW'(pop);
        overflow_d     = overflow_q | (push & full & ~pop);
        result_count_d = result_count_q + 16'(pop);
        out_valid_d    = (count_d != '0);
        out_data_d     = out_data_q;
        if (count_d != '0) begin
            if (write && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = push_data;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array for buffered aligned words
    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers, occupancy and registered output view of the FIFO head
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            overflow_q     <= 1'b0;
            result_count_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            overflow_q     <= overflow_d;
            result_count_q <= result_count_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.overflow     = overflow_q;
    assign bus.result_count = result_count_q;

endmodule

// File: doc/systolic_output_collector.md
# systolic_output_collector

Receive-side companion to the systolic array. It samples the column-skewed `macout` lanes, re-aligns them so all columns of one result vector sit in a single word, and buffers aligned words in a small FIFO. It presents them downstream through a valid/ready handshake and counts delivered results. It sits between the array's bottom edge and the result writer, and never stalls the array.

## Interface

**Parameters**
- `array_size`, default 9: number of columns/lanes; must be ≥ 2.
- `fifo_depth`, default 4: number of aligned-word entries; power of 2, ≥ 2.

**Ports**
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: column 0 of `macin` carries the first lane of a new result vector this cycle.
- `macin`, input, 8*array_size: lane j is bits [8j+7:8j], in the same layout as the array's `macout`.
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: downstream accepts the head.
- `out_data`, output, 8*array_size: aligned result vector, lane j is bits [8j+7:8j].
- `overflow`, output, 1: sticky flag; an aligned word was dropped.
- `result_count`, output, 16: number of words popped; wraps modulo 2^16.

## Operation

- **Skew model.** If `in_valid` is sampled high at edge k, then lane j of that vector is present on `macin` at edge k+j, for j = 0..array_size-1.
- **De-skew.**
  - Lane j goes through a delay line of array_size-1-j registers, so lane array_size-1 has no delay.
  - `in_valid` goes through an array_size-1 stage shift register.
  - When the shifted valid is high at edge k+array_size-1, the word formed from all delay-line outputs is pushed into the FIFO. Lane array_size-1 is taken directly from `macin` at that edge.
- **Back-to-back vectors.** `in_valid` may be high on consecutive cycles. One push occurs per valid, with no bubbles.
- **FIFO.**
  - Circular buffer with read/write pointers and an occupancy count.
  - A pop occurs when `out_valid && out_ready`.
  - `out_data` is the head entry. When `out_valid` is 0, `out_data` holds its last value and is don't-care.
- **Boundary cases.**
  - Push while full with no pop: the word is dropped and `overflow` is set to 1. It stays at 1 until reset.
  - Push while full with a simultaneous pop: both happen and occupancy is unchanged.
  - Push while empty with `out_ready` high: the word is written, and the pop happens in a later cycle. There is no combinational bypass.
  - `out_ready` while empty: no effect.
  - Pointers wrap modulo fifo_depth.
- **result_count.** Increments by 1 on each pop. 0xFFFF wraps to 0x0000.
- **Reset** (also mid-operation):
  - Clears delay lines (all lanes 0), the valid shift register, pointers, occupancy and `result_count`.
  - Clears `overflow`.
  - Vectors still in flight are discarded.
- **Reset values:** `out_valid`=0, `out_data`=0, `overflow`=0, `result_count`=0.

## Timing

- **Push latency.** `in_valid` at edge k produces a push at edge k+array_size-1. With the default array_size=9, that is edge k+8.
- **out_valid rise.** `out_valid` rises in the cycle after the push edge if the FIFO was empty.
- **Throughput.** One vector per clock in, and one per clock out while `out_ready` is held high.
- **Output paths.** `out_valid`, `out_data`, `overflow` and `result_count` are driven from registers only; there is no combinational path from `out_ready`.
- **First cycle after reset.** In the cycle after reset is deasserted, a valid `macin` is accepted if `in_valid`=1.

## Configuration

- **Macro:** `SYSTOLIC_COLLECTOR_RELU_EN`.
- **Defined:** each lane is treated as signed 8-bit at FIFO push time, and negative values (bit 7 = 1) are replaced by 0x00.
- **Undefined:** lanes are stored and output unmodified.

## Test plan

- **Alignment.** array_size=9. Drive lane j = 0x10+j at edge 10+j, with `in_valid` high at edge 10 only, and `out_ready`=1.
  - Push at edge 18.
  - `out_valid` is high for one cycle, with `out_data` lanes 0x10..0x18.
  - `result_count`=1.
- **Burst and backpressure.**
  - Drive 6 consecutive vectors with `out_ready`=0 and fifo_depth=4.
  - After the pushes: 4 entries are held and `overflow`=1.
  - Releasing `out_ready` yields vectors 0..3 in order, and `result_count`=4.
- **Full with simultaneous pop.**
  - Fill the FIFO, then hold `out_ready`=1 while a new vector is pushed.
  - No overflow, occupancy stays at 4, and ordering is preserved.
- **Reset mid-flight.**
  - Assert `reset` 3 cycles after `in_valid`.
  - No push ever occurs for that vector; all outputs return to their reset values.
  - `overflow` is cleared.
- **ReLU.** With the macro defined, drive lanes 0x80, 0xFF, 0x7F, 0x00.
  - Output lanes are 0x00, 0x00, 0x7F, 0x00.
  - Without the macro, the lanes are output unchanged.
- **Counter wrap.**
  - Preload by popping 65536 vectors.
  - `result_count` goes 0xFFFF → 0x0000.
